// File: rtl/ascon_perm_sequencer.sv
// Round sequencer for the ASCON permutation: owns the 320-bit state and steps the round index.
// Optional completed-permutation counter on perm_cnt_o when ASCON_PERM_CNT_EN is defined.
module ascon_perm_sequencer #(
  parameter int unsigned NB_ROUNDS_MAX = 12
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [3:0]       rounds_i,
  input  logic             clear_i,
  // State is five 64-bit words, word 0 in index 0.
  input  logic [4:0][63:0] state_i,
  input  logic [4:0][63:0] perm_state_i,
  output logic [4:0][63:0] state_o,
  output logic [3:0]       round_o,
  output logic             busy_o,
  output logic             done_o
`ifdef ASCON_PERM_CNT_EN
  ,
  output logic [15:0]      perm_cnt_o
`endif
);

  localparam logic [3:0] MaxRounds = 4'(NB_ROUNDS_MAX);
  localparam logic [3:0] LastRound = 4'(NB_ROUNDS_MAX - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [3:0]       round_q, round_d;
  logic [4:0][63:0] state_q, state_d;
  logic [3:0]       eff_rounds;
  logic [3:0]       start_round;

  // Out-of-range round counts fall back to the full p^a permutation.
  always_comb begin
    eff_rounds = rounds_i;
    if (rounds_i == 4'd0 || rounds_i > MaxRounds) begin
      eff_rounds = MaxRounds;
    end
    start_round = MaxRounds - eff_rounds;
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    if (clear_i) begin
      fsm_d   = StIdle;
      round_d = '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (start_i) begin
            state_d = state_i;
            round_d = start_round;
            fsm_d   = StRun;
          end
        end
        StRun: begin
          state_d = perm_state_i;
          if (round_q >= LastRound) begin
            fsm_d = StDone;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
        StDone: begin
          fsm_d = StIdle;
        end
        default: begin
          fsm_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= StIdle;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = (fsm_q == StRun);
  assign done_o  = (fsm_q == StDone);

`ifdef ASCON_PERM_CNT_EN
  logic [15:0] perm_cnt_q;

  // Saturating; deliberately untouched by clear_i.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      perm_cnt_q <= '0;
    end else if (fsm_q == StDone && perm_cnt_q != 16'hFFFF) begin
      perm_cnt_q <= perm_cnt_q + 16'd1;
    end
  end

  assign perm_cnt_o = perm_cnt_q;
`endif

endmodule
